// File: rtl/uart_baud_cfg_ctrl.sv
// uart_baud_cfg_ctrl: validates baud/oversampling requests, quiesces the UART, reprograms the generator and confirms lock
module uart_baud_cfg_ctrl #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned DEFAULT_BAUD = 115200,
    parameter int unsigned DEFAULT_OS   = 16,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned LOCK_EDGES   = 2,
    parameter int unsigned LOCK_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_baud_rate,
    input  logic [4:0]  cfg_os_factor,
    output logic        cfg_err,
    input  logic        tx_busy,
    input  logic        rx_busy,
    output logic        uart_hold,
    output logic        gen_rst,
    output logic [31:0] gen_baud_rate,
    output logic [4:0]  gen_os_factor,
    input  logic        os_tick,
    output logic        link_ready
);
    typedef enum logic [2:0] {APPLY, LOCK, RUN, FAIL, CHECK, DRAIN} state_t;

    localparam logic [36:0] MAX_PROD = 37'(CLK_FREQ / 2);

    state_t      state;
    logic [31:0] sh_baud;
    logic [4:0]  sh_os;
    logic        from_fail;
    logic [31:0] rst_cnt;
    logic [31:0] edge_cnt;
    logic [31:0] to_cnt;
    logic [2:0]  sync;
    logic [36:0] prod;
    logic        legal;
    logic        tick_rise;

    assign prod      = {5'd0, sh_baud} * {32'd0, sh_os};
    assign legal     = (sh_os == 5'd8 || sh_os == 5'd16) && sh_baud != 32'd0 && prod <= MAX_PROD;
    assign tick_rise = sync[1] & ~sync[2];

    // os_tick is asynchronous: two flops to resynchronise, a third keeps the previous value for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[1:0], os_tick};
    end

    // Sequencer: accept, range-check, drain, reset generator, wait for lock; all outputs registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= APPLY;
            sh_baud       <= 32'(DEFAULT_BAUD);
            sh_os         <= 5'(DEFAULT_OS);
            from_fail     <= 1'b0;
            rst_cnt       <= '0;
            edge_cnt      <= '0;
            to_cnt        <= '0;
            gen_baud_rate <= 32'(DEFAULT_BAUD);
            gen_os_factor <= 5'(DEFAULT_OS);
            gen_rst       <= 1'b1;
            uart_hold     <= 1'b1;
            link_ready    <= 1'b0;
            cfg_ready     <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                APPLY: begin
                    if (rst_cnt == RST_CYCLES - 1) begin
                        state    <= LOCK;
                        gen_rst  <= 1'b0;
                        edge_cnt <= '0;
                        to_cnt   <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1;
                    end
                end
                LOCK: begin
                    if (tick_rise && edge_cnt == LOCK_EDGES - 1) begin
                        state      <= RUN;
                        link_ready <= 1'b1;
                        uart_hold  <= 1'b0;
                        cfg_ready  <= 1'b1;
                    end else if (to_cnt == LOCK_TIMEOUT - 1) begin
                        state     <= FAIL;
                        cfg_err   <= 1'b1;
                        cfg_ready <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1;
                        if (tick_rise) edge_cnt <= edge_cnt + 1;
                    end
                end
                RUN, FAIL: begin
                    if (cfg_valid && cfg_ready) begin
                        sh_baud   <= cfg_baud_rate;
                        sh_os     <= cfg_os_factor;
                        from_fail <= state == FAIL;
                        cfg_ready <= 1'b0;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (legal) begin
                        state      <= DRAIN;
                        uart_hold  <= 1'b1;
                        link_ready <= 1'b0;
                    end else begin
                        cfg_err   <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= from_fail ? FAIL : RUN;
                    end
                end
                DRAIN: begin
                    if (!tx_busy && !rx_busy) begin
                        state         <= APPLY;
                        gen_baud_rate <= sh_baud;
                        gen_os_factor <= sh_os;
                        gen_rst       <= 1'b1;
                        rst_cnt       <= '0;
                    end
                end
                default: state <= APPLY;
            endcase
        end
    end
endmodule
